// File: rtl/factorial_queue_engine.sv
// Bus-slave factorial engine: operand FIFO, iterative shift-add multiplier,
// multi-word saturating result register and a maskable level interrupt.
module factorial_queue_engine #(
  parameter int unsigned OP_W      = 8,
  parameter int unsigned RES_WORDS = 2,
  parameter int unsigned DEPTH     = 4,
  parameter logic [15:0] ADDR_BASE = 16'h7000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        s_sel,
  input  logic        s_wr,
  input  logic [15:0] s_addr,
  input  logic [63:0] s_din,
  output logic [63:0] s_dout,
  output logic        interrupt
);

  localparam int unsigned ResW    = 64 * RES_WORDS;
  localparam int unsigned ProdW   = ResW + OP_W;
  localparam int unsigned PtrW    = $clog2(DEPTH);
  localparam int unsigned CntW    = PtrW + 1;
  localparam int unsigned MulCntW = $clog2(OP_W + 1);

  typedef enum logic [2:0] {StIdle, StLoad, StMul, StNext, StDone} state_e;

  state_e state_q, state_d;

  logic               run_q, done_en_q, err_en_q;
  logic               result_valid_q, result_valid_d;
  logic               ovf_q, ovf_d;
  logic               drop_q;
  logic [ResW-1:0]    result_q, result_d;
  logic [ResW-1:0]    acc_q, acc_d;
  logic [OP_W-1:0]    k_q, k_d;
  logic [ProdW-1:0]   p_q, p_d;
  logic [ProdW-1:0]   mcand_q, mcand_d;
  logic [OP_W-1:0]    mplier_q, mplier_d;
  logic [MulCntW-1:0] mcnt_q, mcnt_d;

  logic [OP_W-1:0] fifo_mem [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;

  logic [15:0] offset;
  logic        wr_en, rd_en;
  logic        hit_ctrl, hit_inten, hit_status, hit_op;
  logic        clear, ack, full, empty, push_req, push_ok, pop, busy;
  logic [63:0] rdata;

  assign wr_en      = s_sel & s_wr;
  assign rd_en      = s_sel & ~s_wr;
  assign offset     = s_addr - ADDR_BASE;
  assign hit_ctrl   = (offset == 16'h0000);
  assign hit_inten  = (offset == 16'h0008);
  assign hit_status = (offset == 16'h0010);
  assign hit_op     = (offset == 16'h0018);

  assign clear    = wr_en & hit_ctrl & s_din[1];
  // ACK is only meaningful while a result is pending.
  assign ack      = wr_en & hit_ctrl & s_din[2] & result_valid_q;
  assign full     = (count_q == CntW'(DEPTH));
  assign empty    = (count_q == '0);
  assign push_req = wr_en & hit_op;
  assign push_ok  = push_req & ~full & ~clear;
  assign pop      = (state_q == StIdle) & run_q & ~empty & ~result_valid_q & ~clear;
  assign busy     = (state_q != StIdle);

  assign interrupt = (done_en_q & result_valid_q) | (err_en_q & (ovf_q | drop_q));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) fifo_mem[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        fifo_mem[wr_ptr_q] <= s_din[OP_W-1:0];
        wr_ptr_q           <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_ok && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push_ok) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q     <= 1'b0;
      done_en_q <= 1'b0;
      err_en_q  <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      // A CLEAR write leaves RUN as it was.
      if (wr_en && hit_ctrl && !s_din[1]) run_q <= s_din[0];
      if (wr_en && hit_inten) begin
        done_en_q <= s_din[0];
        err_en_q  <= s_din[1];
      end
      if (clear)                drop_q <= 1'b0;
      else if (push_req && full) drop_q <= 1'b1;
    end
  end

  always_comb begin
    state_d        = state_q;
    result_valid_d = result_valid_q;
    ovf_d          = ovf_q;
    result_d       = result_q;
    acc_d          = acc_q;
    k_d            = k_q;
    p_d            = p_q;
    mcand_d        = mcand_q;
    mplier_d       = mplier_q;
    mcnt_d         = mcnt_q;

    if (ack) begin
      result_valid_d = 1'b0;
      ovf_d          = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (pop) begin
          k_d     = fifo_mem[rd_ptr_q];
          state_d = StLoad;
        end
      end
      StLoad: begin
        acc_d = ResW'(1);
        if (k_q <= OP_W'(1)) begin
          state_d = StDone;
        end else begin
          p_d      = '0;
          mcand_d  = ProdW'(1);
          mplier_d = k_q;
          mcnt_d   = '0;
          state_d  = StMul;
        end
      end
      StMul: begin
        if (mplier_q[0]) p_d = p_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        mcnt_d   = mcnt_q + 1'b1;
        if (mcnt_q == MulCntW'(OP_W - 1)) state_d = StNext;
      end
      StNext: begin
        if (|p_q[ProdW-1:ResW]) begin
          acc_d   = '1;
          ovf_d   = 1'b1;
          state_d = StDone;
        end else begin
          acc_d = p_q[ResW-1:0];
          k_d   = k_q - OP_W'(1);
          if (k_q == OP_W'(2)) begin
            state_d = StDone;
          end else begin
            p_d      = '0;
            mcand_d  = {{OP_W{1'b0}}, p_q[ResW-1:0]};
            mplier_d = k_q - OP_W'(1);
            mcnt_d   = '0;
            state_d  = StMul;
          end
        end
      end
      StDone: begin
        result_d       = acc_q;
        result_valid_d = 1'b1;
        state_d        = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (clear) begin
      state_d        = StIdle;
      result_valid_d = 1'b0;
      ovf_d          = 1'b0;
      result_d       = '0;
      acc_d          = '0;
      k_d            = '0;
      p_d            = '0;
      mcand_d        = '0;
      mplier_d       = '0;
      mcnt_d         = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= StIdle;
      result_valid_q <= 1'b0;
      ovf_q          <= 1'b0;
      result_q       <= '0;
      acc_q          <= '0;
      k_q            <= '0;
      p_q            <= '0;
      mcand_q        <= '0;
      mplier_q       <= '0;
      mcnt_q         <= '0;
    end else begin
      state_q        <= state_d;
      result_valid_q <= result_valid_d;
      ovf_q          <= ovf_d;
      result_q       <= result_d;
      acc_q          <= acc_d;
      k_q            <= k_d;
      p_q            <= p_d;
      mcand_q        <= mcand_d;
      mplier_q       <= mplier_d;
      mcnt_q         <= mcnt_d;
    end
  end

  always_comb begin
    rdata = '0;
    if (hit_ctrl) begin
      rdata[0] = run_q;
    end else if (hit_inten) begin
      rdata[1:0] = {err_en_q, done_en_q};
    end else if (hit_status) begin
      rdata[0]    = busy;
      rdata[1]    = result_valid_q;
      rdata[2]    = ovf_q;
      rdata[3]    = full;
      rdata[4]    = empty;
      rdata[5]    = drop_q;
      rdata[15:8] = 8'(count_q);
    end else begin
      for (int unsigned i = 0; i < RES_WORDS; i++) begin
        if (offset == 16'(32 + 8 * i)) rdata = result_q[64*i +: 64];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) s_dout <= '0;
    else          s_dout <= rd_en ? rdata : 64'd0;
  end

endmodule

// File: tb/tb_factorial_queue_engine.sv
// Directed bench for factorial_queue_engine: bus writes/reads with
// hand-computed expected values checked by immediate assertions.
module tb_factorial_queue_engine;

  localparam logic [15:0] Base   = 16'h7000;
  localparam logic [15:0] Ctrl   = Base + 16'h00;
  localparam logic [15:0] Inten  = Base + 16'h08;
  localparam logic [15:0] Status = Base + 16'h10;
  localparam logic [15:0] Oper   = Base + 16'h18;
  localparam logic [15:0] Res0   = Base + 16'h20;
  localparam logic [15:0] Res1   = Base + 16'h28;

  logic        clk;
  logic        reset_n;
  logic        s_sel;
  logic        s_wr;
  logic [15:0] s_addr;
  logic [63:0] s_din;
  logic [63:0] s_dout;
  logic        interrupt;

  int total = 0;
  int bad   = 0;

  factorial_queue_engine #(
    .OP_W      (8),
    .RES_WORDS (2),
    .DEPTH     (4),
    .ADDR_BASE (16'h7000)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .s_sel     (s_sel),
    .s_wr      (s_wr),
    .s_addr    (s_addr),
    .s_din     (s_din),
    .s_dout    (s_dout),
    .interrupt (interrupt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [15:0] addr, input logic [63:0] data);
    @(negedge clk);
    s_sel  = 1'b1;
    s_wr   = 1'b1;
    s_addr = addr;
    s_din  = data;
    @(negedge clk);
    s_sel  = 1'b0;
    s_wr   = 1'b0;
    s_din  = '0;
  endtask

  task automatic bus_read(input logic [15:0] addr, output logic [63:0] data);
    @(negedge clk);
    s_sel  = 1'b1;
    s_wr   = 1'b0;
    s_addr = addr;
    @(negedge clk);
    data   = s_dout;
    s_sel  = 1'b0;
  endtask

  // Counts negedges until interrupt rises, bounded by budget.
  task automatic wait_irq(input int budget, output int cyc);
    cyc = 0;
    while (interrupt !== 1'b1 && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  logic [63:0]  rd;
  logic [127:0] f34;
  int           cyc;

  initial begin
    reset_n = 1'b0;
    s_sel   = 1'b0;
    s_wr    = 1'b0;
    s_addr  = '0;
    s_din   = '0;
    f34     = 128'd1;
    for (int i = 2; i <= 34; i++) f34 = f34 * 128'(i);

    repeat (3) @(negedge clk);
    check("rst_dout", s_dout, 0);
    check("rst_irq", interrupt, 0);
    reset_n = 1'b1;
    bus_read(Status, rd);
    check("rst_status", rd, 64'h10);

    // 10! with DONE interrupt and exact latency
    bus_write(Oper, 64'd10);
    bus_read(Status, rd);
    check("status_one_queued", rd, 64'h0100);
    bus_write(Inten, 64'h1);
    bus_write(Ctrl, 64'h1);
    wait_irq(1000, cyc);
    check("lat_10", cyc, 84);
    bus_read(Res0, rd);
    check("res0_10", rd, 64'h375F00);
    bus_read(Res1, rd);
    check("res1_10", rd, 64'h0);
    bus_read(Status, rd);
    check("status_valid", rd, 64'h12);
    bus_read(Ctrl, rd);
    check("ctrl_read", rd, 64'h1);
    bus_write(Ctrl, 64'h5);
    check("irq_after_ack", interrupt, 0);

    // 0!, 1!, 20!
    bus_write(Oper, 64'd0);
    wait_irq(1000, cyc);
    check("lat_0", cyc, 3);
    bus_read(Res0, rd);
    check("res0_0", rd, 64'h1);
    bus_write(Ctrl, 64'h5);
    bus_write(Oper, 64'd1);
    wait_irq(1000, cyc);
    check("lat_1", cyc, 3);
    bus_read(Res0, rd);
    check("res0_1", rd, 64'h1);
    bus_read(Res1, rd);
    check("res1_1", rd, 64'h0);
    bus_write(Ctrl, 64'h5);
    bus_write(Oper, 64'd20);
    wait_irq(1000, cyc);
    check("irq_20", interrupt, 1);
    bus_read(Res0, rd);
    check("res0_20", rd, 64'h21C3677C82B40000);
    bus_read(Res1, rd);
    check("res1_20", rd, 64'h0);
    bus_write(Ctrl, 64'h5);

    // 34! fits, 35! saturates
    bus_write(Oper, 64'd34);
    wait_irq(1000, cyc);
    bus_read(Status, rd);
    check("status_34", rd, 64'h12);
    bus_read(Res0, rd);
    check("res0_34", rd, f34[63:0]);
    bus_read(Res1, rd);
    check("res1_34", rd, f34[127:64]);
    check("res1_34_nonzero", (rd != 64'd0), 1);
    bus_write(Ctrl, 64'h5);
    bus_write(Oper, 64'd35);
    wait_irq(1000, cyc);
    bus_read(Status, rd);
    check("status_35_ovf", rd, 64'h16);
    bus_read(Res0, rd);
    check("res0_35", rd, 64'hFFFF_FFFF_FFFF_FFFF);
    bus_read(Res1, rd);
    check("res1_35", rd, 64'hFFFF_FFFF_FFFF_FFFF);
    bus_write(Inten, 64'h0);
    check("irq_ovf_masked", interrupt, 0);
    bus_write(Inten, 64'h2);
    check("irq_ovf_err_en", interrupt, 1);
    bus_write(Ctrl, 64'h5);
    check("irq_ovf_acked", interrupt, 0);
    bus_read(Status, rd);
    check("status_after_ack", rd, 64'h10);

    // Overfill with RUN off, then CLEAR
    bus_write(Ctrl, 64'h0);
    for (int i = 1; i <= 5; i++) bus_write(Oper, 64'(i));
    bus_read(Status, rd);
    check("status_full_drop", rd, 64'h0428);
    check("irq_drop", interrupt, 1);
    bus_write(Ctrl, 64'h2);
    bus_read(Status, rd);
    check("status_cleared", rd, 64'h10);
    check("irq_cleared", interrupt, 0);

    // 30! interrupted by asynchronous reset with outputs non-zero
    bus_write(Oper, 64'd30);
    for (int i = 0; i < 4; i++) bus_write(Oper, 64'd1);
    bus_write(Ctrl, 64'h1);
    repeat (10) @(negedge clk);
    s_sel  = 1'b1;
    s_wr   = 1'b0;
    s_addr = Status;
    @(negedge clk);
    check("status_mid_mul", s_dout, 64'h0321);
    check("irq_before_reset", interrupt, 1);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_dout", s_dout, 0);
    check("async_rst_irq", interrupt, 0);
    s_sel = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    bus_read(Ctrl, rd);
    check("ctrl_after_reset", rd, 64'h0);
    bus_read(Status, rd);
    check("status_after_reset", rd, 64'h10);
    bus_write(Inten, 64'h1);
    bus_write(Ctrl, 64'h1);
    bus_write(Oper, 64'd3);
    wait_irq(1000, cyc);
    check("lat_3", cyc, 2 + 2 * 9 + 1);
    bus_read(Res0, rd);
    check("res0_3", rd, 64'd6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
